// File: rtl/spi_flash_stream_reader.sv
// -----------------------------------------------------------------------------
// spi_flash_stream_reader
//
// SPI mode-0 flash read engine. A request carries a start address and a byte
// count. The engine sends the read command and an ADDR_W-bit address, then
// streams the received bytes out over a valid/ready handshake. When the
// consumer stalls, SCK is parked low, so no flash bits are lost.
//
// Build option:
//   SPI_FAST_READ_EN  When defined, the engine sends command 0x0B and inserts
//                     one dummy byte (8 SCK, MOSI=0, MISO ignored) between the
//                     address and the data. When undefined, it sends command
//                     0x03 and has no dummy phase.
//
// Ports:
//   i_clk           system clock, all logic on posedge
//   i_rst_n         asynchronous active-low reset
//   i_start         one-cycle request, accepted only while idle
//   i_start_addr    flash byte address, latched on an accepted start
//   i_byte_count    number of bytes to read, latched on an accepted start
//   i_abort         cancels the transaction in progress
//   o_busy          high from the accepted start until the engine is idle again
//   o_data_out      received byte (MSB first on the wire)
//   o_data_valid    o_data_out holds a byte that has not been taken
//   i_data_ready    consumer takes the byte when valid & ready
//   o_done          one-cycle pulse when a complete transfer has finished
//   o_spi_cs_n      flash chip select, active low
//   o_spi_sck       SPI clock, idles low
//   o_spi_mosi      command/address bits, change on SCK fall
//   i_spi_miso      flash data, sampled on SCK rise
// -----------------------------------------------------------------------------
module spi_flash_stream_reader #(
    parameter int ADDR_W  = 24,
    parameter int LEN_W   = 16,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [LEN_W-1:0]  i_byte_count,
    input  logic              i_abort,
    output logic              o_busy,
    output logic [7:0]        o_data_out,
    output logic              o_data_valid,
    input  logic              i_data_ready,
    output logic              o_done,
    output logic              o_spi_cs_n,
    output logic              o_spi_sck,
    output logic              o_spi_mosi,
    input  logic              i_spi_miso
);

    localparam int         HDR_W     = 8 + ADDR_W;
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = (CS_GAP > 0) ? 16'(CS_GAP - 1) : 16'd0;
    localparam logic [5:0]  ADDR_BITS = 6'(ADDR_W);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] READ_CMD = 8'h0B;
`else
    localparam logic [7:0] READ_CMD = 8'h03;
`endif

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_STALL,
        ST_CS_HOLD,
        ST_GAP
    } state_t;

    // Registered state
    state_t             r_state;
    logic               r_cs_n;
    logic               r_sck;
    logic [HDR_W-1:0]   r_hdr;      // command+address shifter, MSB drives MOSI
    logic [15:0]        r_tmr;      // SCK half-period / CS timing counter
    logic [5:0]         r_bit;      // SCK rises within the current phase
    logic [7:0]         r_rx;       // MISO shifter
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_pend;     // r_rx holds a complete byte not yet in r_data
    logic [LEN_W-1:0]   r_cnt;      // bytes still to be placed in r_data
    logic [LEN_W-1:0]   r_rxcnt;    // bytes still to be shifted in from flash
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;

    // Next-state values
    state_t             w_state;
    logic               w_cs_n;
    logic               w_sck;
    logic [HDR_W-1:0]   w_hdr;
    logic [15:0]        w_tmr;
    logic [5:0]         w_bit;
    logic [7:0]         w_rx;
    logic [7:0]         w_data;
    logic               w_valid;
    logic               w_pend;
    logic [LEN_W-1:0]   w_cnt;
    logic [LEN_W-1:0]   w_rxcnt;
    logic               w_busy;
    logic               w_done;
    logic               w_aborted;
    logic               w_zero_start;

    logic               w_tick;
    logic               w_slot_free;
    logic [7:0]         w_rx_byte;

    function automatic logic [LEN_W-1:0] dec_sat(input logic [LEN_W-1:0] v);
        return (v != '0) ? (v - LEN_W'(1)) : '0;
    endfunction

    assign w_tick      = (r_tmr == DIV_LAST);
    assign w_slot_free = !r_valid || i_data_ready;
    assign w_rx_byte   = {r_rx[6:0], i_spi_miso};

    always_comb begin
        w_state      = r_state;
        w_cs_n       = r_cs_n;
        w_sck        = r_sck;
        w_hdr        = r_hdr;
        w_tmr        = r_tmr;
        w_bit        = r_bit;
        w_rx         = r_rx;
        w_data       = r_data;
        w_valid      = r_valid && !i_data_ready;
        w_pend       = r_pend;
        w_cnt        = r_cnt;
        w_rxcnt      = r_rxcnt;
        w_done       = 1'b0;
        w_aborted    = r_aborted;
        w_zero_start = 1'b0;

        // A parked byte moves to the output as soon as the output slot frees,
        // whatever state the engine is in.
        if (r_pend && w_slot_free) begin
            w_data  = r_rx;
            w_valid = 1'b1;
            w_pend  = 1'b0;
            w_cnt   = dec_sat(r_cnt);
        end

        case (r_state)
            ST_IDLE: begin
                w_cs_n = 1'b1;
                w_sck  = 1'b0;
                // r_busy is only high here in the cycle after a zero-length
                // request, which keeps that request's busy cycle exclusive.
                if (i_start && !r_busy) begin
                    if (i_byte_count == '0) begin
                        w_zero_start = 1'b1;
                    end else begin
                        w_state   = ST_CS_SETUP;
                        w_cs_n    = 1'b0;
                        w_hdr     = {READ_CMD, i_start_addr};
                        w_tmr     = '0;
                        w_bit     = '0;
                        w_cnt     = i_byte_count;
                        w_rxcnt   = i_byte_count;
                        w_pend    = 1'b0;
                        w_aborted = 1'b0;
                    end
                end
            end

            ST_CS_SETUP: begin
                w_tmr = r_tmr + 16'd1;
                if (w_tick) begin
                    w_tmr   = '0;
                    w_sck   = 1'b1;
                    w_bit   = 6'd1;
                    w_state = ST_CMD;
                end
            end

            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                w_tmr = r_tmr + 16'd1;
                if (w_tick) begin
                    w_tmr = '0;
                    if (!r_sck) begin
                        // Rising edge: MISO sampled here
                        w_sck = 1'b1;
                        w_bit = r_bit + 6'd1;
                        if (r_state == ST_DATA) begin
                            w_rx = w_rx_byte;
                            if (r_bit == 6'd7) begin
                                w_rxcnt = dec_sat(r_rxcnt);
                                if (w_slot_free) begin
                                    w_data  = w_rx_byte;
                                    w_valid = 1'b1;
                                    w_cnt   = dec_sat(r_cnt);
                                end else begin
                                    w_pend = 1'b1;
                                end
                            end
                        end
                    end else begin
                        // Falling edge: next MOSI bit; zeros fill behind the address
                        w_sck = 1'b0;
                        w_hdr = {r_hdr[HDR_W-2:0], 1'b0};
                        if (r_state == ST_CMD && r_bit == 6'd8) begin
                            w_state = ST_ADDR;
                            w_bit   = '0;
                        end else if (r_state == ST_ADDR && r_bit == ADDR_BITS) begin
                            w_bit = '0;
`ifdef SPI_FAST_READ_EN
                            w_state = ST_DUMMY;
`else
                            w_state = ST_DATA;
`endif
                        end else if (r_state == ST_DUMMY && r_bit == 6'd8) begin
                            w_state = ST_DATA;
                            w_bit   = '0;
                        end else if (r_state == ST_DATA && r_bit == 6'd8) begin
                            w_bit = '0;
                            if (r_rxcnt == '0) begin
                                w_state = ST_CS_HOLD;
                            end else if (r_pend && !w_slot_free) begin
                                // Shifter and output both full: park SCK low
                                w_state = ST_STALL;
                            end
                        end
                    end
                end
            end

            ST_STALL: begin
                w_sck = 1'b0;
                // The parked byte lands this cycle; the next rise comes
                // a full half-period later.
                if (w_slot_free) begin
                    w_state = ST_DATA;
                    w_tmr   = '0;
                end
            end

            ST_CS_HOLD: begin
                w_tmr = r_tmr + 16'd1;
                if (w_tick) begin
                    w_cs_n  = 1'b1;
                    w_state = ST_GAP;
                    w_tmr   = '0;
                end
            end

            ST_GAP: begin
                w_cs_n = 1'b1;
                w_sck  = 1'b0;
                if (r_tmr != 16'hFFFF) begin
                    w_tmr = r_tmr + 16'd1;
                end
                // A completed transfer also waits for its last byte to be taken
                if (r_tmr >= GAP_LAST &&
                    (r_aborted ||
                     (r_cnt == '0 && !r_pend && (!r_valid || i_data_ready)))) begin
                    w_state = ST_IDLE;
                    w_done  = !r_aborted;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase

        if (i_abort && r_state != ST_IDLE) begin
            w_state   = ST_GAP;
            w_cs_n    = 1'b1;
            w_sck     = 1'b0;
            w_valid   = 1'b0;
            w_pend    = 1'b0;
            w_hdr     = '0;
            w_tmr     = '0;
            w_aborted = 1'b1;
            w_done    = 1'b0;
        end

        if (w_zero_start) begin
            w_done = 1'b1;
        end
        w_busy = (w_state != ST_IDLE) || w_zero_start;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cs_n    <= 1'b1;
            r_sck     <= 1'b0;
            r_hdr     <= '0;
            r_tmr     <= '0;
            r_bit     <= '0;
            r_rx      <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_pend    <= 1'b0;
            r_cnt     <= '0;
            r_rxcnt   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cs_n    <= w_cs_n;
            r_sck     <= w_sck;
            r_hdr     <= w_hdr;
            r_tmr     <= w_tmr;
            r_bit     <= w_bit;
            r_rx      <= w_rx;
            r_data    <= w_data;
            r_valid   <= w_valid;
            r_pend    <= w_pend;
            r_cnt     <= w_cnt;
            r_rxcnt   <= w_rxcnt;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_aborted <= w_aborted;
        end
    end

    assign o_busy       = r_busy;
    assign o_data_out   = r_data;
    assign o_data_valid = r_valid;
    assign o_done       = r_done;
    assign o_spi_cs_n   = r_cs_n;
    assign o_spi_sck    = r_sck;
    assign o_spi_mosi   = r_hdr[HDR_W-1];

endmodule

// File: tb/tb_spi_flash_stream_reader.sv
module tb_spi_flash_stream_reader;

`ifdef SPI_FAST_READ_EN
    localparam int HDR = 40;
`else
    localparam int HDR = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic [23:0] start_addr = '0;
    logic [15:0] byte_count = '0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic        miso = 1'b1;
    logic        o_busy, o_data_valid, o_done, o_spi_cs_n, o_spi_sck, o_spi_mosi;
    logic [7:0]  o_data_out;

    int n_chk = 0;
    int n_pass = 0;

    spi_flash_stream_reader #(
        .ADDR_W(24), .LEN_W(16), .CLK_DIV(2), .CS_GAP(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_start_addr(start_addr),
        .i_byte_count(byte_count), .i_abort(abort), .o_busy(o_busy),
        .o_data_out(o_data_out), .o_data_valid(o_data_valid), .i_data_ready(ready),
        .o_done(o_done), .o_spi_cs_n(o_spi_cs_n), .o_spi_sck(o_spi_sck),
        .o_spi_mosi(o_spi_mosi), .i_spi_miso(miso)
    );

    always #5 clk = ~clk;

    // ---------------- flash model ----------------
    logic [7:0]  fbytes [8];
    logic [63:0] mosi_cap = '0;
    int          nrise = 0;
    logic        m_prev_cs = 1'b1;
    logic        m_prev_sck = 1'b0;

    always @(o_spi_cs_n or o_spi_sck) begin
        if (m_prev_cs && !o_spi_cs_n) begin
            nrise = 0;
            mosi_cap = '0;
            miso = 1'b1;
        end
        if (!o_spi_cs_n) begin
            if (!m_prev_sck && o_spi_sck) begin
                if (nrise < HDR) mosi_cap = {mosi_cap[62:0], o_spi_mosi};
                nrise = nrise + 1;
            end
            if (m_prev_sck && !o_spi_sck) begin
                if (nrise >= HDR && (nrise - HDR) / 8 < 8)
                    miso = fbytes[(nrise - HDR) / 8][7 - ((nrise - HDR) % 8)];
                else
                    miso = 1'b1;
            end
        end
        m_prev_cs = o_spi_cs_n;
        m_prev_sck = o_spi_sck;
    end

    // ---------------- consumer / monitors ----------------
    logic [7:0] got [$];
    int   done_cnt = 0;
    int   valid_cnt = 0;
    int   cs_falls = 0;
    int   stab_err = 0;
    logic mon_prev_cs = 1'b1;
    logic hold_prev = 1'b0;
    logic [7:0] hold_data = '0;

    always @(negedge clk) begin
        if (o_data_valid && ready) got.push_back(o_data_out);
        if (o_done) done_cnt = done_cnt + 1;
        if (o_data_valid) valid_cnt = valid_cnt + 1;
        if (mon_prev_cs && !o_spi_cs_n) cs_falls = cs_falls + 1;
        mon_prev_cs = o_spi_cs_n;
        if (hold_prev && (!o_data_valid || o_data_out !== hold_data)) stab_err = stab_err + 1;
        hold_prev = o_data_valid && !ready;
        hold_data = o_data_out;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [23:0] a, input logic [15:0] n);
        start_addr = a;
        byte_count = n;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    function automatic logic [63:0] exp_hdr(input logic [23:0] a);
`ifdef SPI_FAST_READ_EN
        return {24'd0, 8'h0B, a, 8'h00};
`else
        return {32'd0, 8'h03, a};
`endif
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        n_chk++; if (o_spi_cs_n !== 1'b1) $display("FAIL rst_cs_n: got %b want 1", o_spi_cs_n); else n_pass++;
        n_chk++; if (o_spi_sck !== 1'b0) $display("FAIL rst_sck: got %b want 0", o_spi_sck); else n_pass++;
        n_chk++; if (o_spi_mosi !== 1'b0) $display("FAIL rst_mosi: got %b want 0", o_spi_mosi); else n_pass++;
        n_chk++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_busy); else n_pass++;
        n_chk++; if (o_data_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", o_data_valid); else n_pass++;
        n_chk++; if (o_data_out !== 8'h00) $display("FAIL rst_data: got %h want 00", o_data_out); else n_pass++;
        n_chk++; if (o_done !== 1'b0) $display("FAIL rst_done: got %b want 0", o_done); else n_pass++;
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_read_basic();
        int base, d0;
        logic [7:0] exp [4];
        exp = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        for (int i = 0; i < 8; i++) fbytes[i] = (i < 4) ? exp[i] : 8'h77;
        base = got.size();
        d0 = done_cnt;
        ready = 1'b1;
        kick(24'h000100, 16'd4);
        n_chk++; if (o_busy !== 1'b1) $display("FAIL basic_busy_start: got %b want 1", o_busy); else n_pass++;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) step(1);
        step(2);
        n_chk++; if (done_cnt - d0 !== 1) $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0); else n_pass++;
        n_chk++; if (mosi_cap !== exp_hdr(24'h000100)) $display("FAIL basic_mosi: got %h want %h", mosi_cap, exp_hdr(24'h000100)); else n_pass++;
        n_chk++; if (got.size() - base !== 4) $display("FAIL basic_nbytes: got %0d want 4", got.size() - base); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (got.size() <= base + i || got[base + i] !== exp[i])
                $display("FAIL basic_byte%0d: got %h want %h", i, (got.size() > base + i) ? got[base + i] : 8'hxx, exp[i]);
            else n_pass++;
        end
        n_chk++; if (nrise !== HDR + 32) $display("FAIL basic_sck_rises: got %0d want %0d", nrise, HDR + 32); else n_pass++;
        n_chk++; if (o_spi_cs_n !== 1'b1) $display("FAIL basic_cs_after: got %b want 1", o_spi_cs_n); else n_pass++;
        n_chk++; if (o_busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", o_busy); else n_pass++;
    endtask

    task automatic test_backpressure();
        int base, d0, r0, s0;
        logic [7:0] exp [4];
        exp = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) fbytes[i] = exp[i];
        base = got.size();
        d0 = done_cnt;
        s0 = stab_err;
        ready = 1'b0;
        kick(24'h000100, 16'd4);
        for (int i = 0; i < 1000 && !o_data_valid; i++) step(1);
        r0 = nrise;
        step(40);
        n_chk++; if (nrise - r0 !== 8) $display("FAIL bp_rises_in_stall: got %0d want 8", nrise - r0); else n_pass++;
        n_chk++; if (o_spi_sck !== 1'b0) $display("FAIL bp_sck_parked: got %b want 0", o_spi_sck); else n_pass++;
        n_chk++; if (o_spi_cs_n !== 1'b0) $display("FAIL bp_cs_held: got %b want 0", o_spi_cs_n); else n_pass++;
        n_chk++; if (o_data_valid !== 1'b1) $display("FAIL bp_valid_held: got %b want 1", o_data_valid); else n_pass++;
        n_chk++; if (o_data_out !== 8'hA5) $display("FAIL bp_data_held: got %h want a5", o_data_out); else n_pass++;
        ready = 1'b1;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) step(1);
        step(2);
        n_chk++; if (done_cnt - d0 !== 1) $display("FAIL bp_done_pulses: got %0d want 1", done_cnt - d0); else n_pass++;
        n_chk++; if (got.size() - base !== 4) $display("FAIL bp_nbytes: got %0d want 4", got.size() - base); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (got.size() <= base + i || got[base + i] !== exp[i])
                $display("FAIL bp_byte%0d: got %h want %h", i, (got.size() > base + i) ? got[base + i] : 8'hxx, exp[i]);
            else n_pass++;
        end
        n_chk++; if (stab_err - s0 !== 0) $display("FAIL bp_data_stability: got %0d violations want 0", stab_err - s0); else n_pass++;
        n_chk++; if (nrise !== HDR + 32) $display("FAIL bp_sck_rises: got %0d want %0d", nrise, HDR + 32); else n_pass++;
    endtask

    task automatic test_zero_count();
        int c0, v0, d0;
        c0 = cs_falls;
        v0 = valid_cnt;
        d0 = done_cnt;
        ready = 1'b1;
        kick(24'h000200, 16'd0);
        n_chk++; if (o_busy !== 1'b1) $display("FAIL zero_busy1: got %b want 1", o_busy); else n_pass++;
        n_chk++; if (o_done !== 1'b1) $display("FAIL zero_done1: got %b want 1", o_done); else n_pass++;
        step(1);
        n_chk++; if (o_busy !== 1'b0) $display("FAIL zero_busy2: got %b want 0", o_busy); else n_pass++;
        n_chk++; if (o_done !== 1'b0) $display("FAIL zero_done2: got %b want 0", o_done); else n_pass++;
        step(10);
        n_chk++; if (cs_falls !== c0) $display("FAIL zero_cs_falls: got %0d want %0d", cs_falls, c0); else n_pass++;
        n_chk++; if (valid_cnt !== v0) $display("FAIL zero_valid_cycles: got %0d want %0d", valid_cnt, v0); else n_pass++;
        n_chk++; if (done_cnt - d0 !== 1) $display("FAIL zero_done_pulses: got %0d want 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_abort();
        int base, c0, d0;
        for (int i = 0; i < 8; i++) fbytes[i] = 8'h10 + 8'(i);
        base = got.size();
        c0 = cs_falls;
        d0 = done_cnt;
        ready = 1'b1;
        kick(24'h000300, 16'd8);
        for (int i = 0; i < 3000 && got.size() - base < 2; i++) step(1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        n_chk++; if (o_spi_cs_n !== 1'b1) $display("FAIL abort_cs: got %b want 1", o_spi_cs_n); else n_pass++;
        n_chk++; if (o_spi_sck !== 1'b0) $display("FAIL abort_sck: got %b want 0", o_spi_sck); else n_pass++;
        n_chk++; if (o_data_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", o_data_valid); else n_pass++;
        // Request while the engine is still in its CS gap
        kick(24'h000400, 16'd4);
        step(30);
        n_chk++; if (cs_falls - c0 !== 1) $display("FAIL abort_start_ignored: got %0d cs falls want 1", cs_falls - c0); else n_pass++;
        n_chk++; if (done_cnt !== d0) $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); else n_pass++;
        n_chk++; if (got.size() - base !== 2) $display("FAIL abort_nbytes: got %0d want 2", got.size() - base); else n_pass++;
        n_chk++; if (got.size() < base + 2 || got[base + 1] !== 8'h11) $display("FAIL abort_byte1: got %h want 11", (got.size() >= base + 2) ? got[base + 1] : 8'hxx); else n_pass++;
        n_chk++; if (o_busy !== 1'b0) $display("FAIL abort_busy_after: got %b want 0", o_busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base;
        for (int i = 0; i < 8; i++) fbytes[i] = 8'h5A;
        base = got.size();
        ready = 1'b1;
        kick(24'h000500, 16'd8);
        for (int i = 0; i < 3000 && got.size() - base < 1; i++) step(1);
        step(5);
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++; if (o_spi_cs_n !== 1'b1) $display("FAIL midrst_cs: got %b want 1", o_spi_cs_n); else n_pass++;
        n_chk++; if (o_spi_sck !== 1'b0) $display("FAIL midrst_sck: got %b want 0", o_spi_sck); else n_pass++;
        n_chk++; if (o_data_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", o_data_valid); else n_pass++;
        n_chk++; if (o_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", o_busy); else n_pass++;
        step(2);
        rst_n = 1'b1;
        step(3);
        n_chk++; if (o_busy !== 1'b0 || o_spi_cs_n !== 1'b1) $display("FAIL midrst_idle: got busy=%b cs_n=%b want 0/1", o_busy, o_spi_cs_n); else n_pass++;
    endtask

    task automatic test_fast_read();
        int base, d0;
        for (int i = 0; i < 8; i++) fbytes[i] = (i == 0) ? 8'hC3 : 8'h99;
        base = got.size();
        d0 = done_cnt;
        ready = 1'b1;
        kick(24'h123456, 16'd1);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) step(1);
        step(2);
        n_chk++; if (mosi_cap !== exp_hdr(24'h123456)) $display("FAIL fast_mosi: got %h want %h", mosi_cap, exp_hdr(24'h123456)); else n_pass++;
        n_chk++; if (nrise !== HDR + 8) $display("FAIL fast_sck_rises: got %0d want %0d", nrise, HDR + 8); else n_pass++;
        n_chk++; if (got.size() - base !== 1) $display("FAIL fast_nbytes: got %0d want 1", got.size() - base); else n_pass++;
        n_chk++; if (got.size() < base + 1 || got[base] !== 8'hC3) $display("FAIL fast_byte0: got %h want c3", (got.size() > base) ? got[base] : 8'hxx); else n_pass++;
        n_chk++; if (done_cnt - d0 !== 1) $display("FAIL fast_done_pulses: got %0d want 1", done_cnt - d0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_backpressure();
        test_zero_count();
        test_abort();
        test_reset_mid();
        test_fast_read();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
